sym_mat_unpack_tx: RTL and testbench
====================================

Name: sym_mat_unpack_tx

Overview:
- Consumer end of the matrix-multiply result interface. Watches the product unit's done flag (`ctrl_etme`) and captures the six upper-triangle words of the symmetric 3x3 result (m0,m1,m2,m4,m5,m8).
- Expands them to a full 9-element row-major matrix and streams one element per beat over a valid/ready interface to the OBB separating-axis stage.
- Provides the trace (m0+m4+m8) and frame/overrun status as sideband.

Parameters:
- INIT_STATE, 4'b0010, top-level `state` encoding that reinitialises the datapath; this block aborts and clears on it.
- DW, 21, signed element width (6 fractional bits; the block only passes values through).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- state  in  4  top-level FSM state
- ctrl_etme  in  1  product-done flag; level, held high until next INIT_STATE
- m0,m1,m2,m4,m5,m8  in  DW each  signed upper-triangle result words
- out_valid  out  1  element beat valid
- out_ready  in  1  downstream accept
- out_data  out  DW  signed element value
- out_idx  out  4  row-major element index 0..8
- out_last  out  1  high with idx 8
- trace  out  DW+2  signed m0+m4+m8 of the captured frame
- busy  out  1  high while a frame is captured and not fully sent
- overrun  out  1  sticky: done edge arrived while busy
- frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (rst=1, highest priority):
  - out_valid=0, out_idx=0, out_last=0, busy=0, overrun=0, frame_cnt=0, trace=0.
  - All capture registers=0, so out_data=0.
  - Edge-detect register etme_d=0.
- Edge detect: etme_d <= ctrl_etme every cycle. Capture event = ctrl_etme & ~etme_d. A level held high never retriggers.
- FSM states: IDLE, STREAM.
- IDLE:
  - On capture event at clock edge N, register the six words.
  - Also register trace = sign-extended sum (DW+2 bits, no overflow possible).
  - At N+1: out_valid=1, out_idx=0, busy=1, state STREAM. Capture-to-first-valid latency is 1 cycle.
- STREAM:
  - out_data mux by out_idx: 0:m0 1:m1 2:m2 3:m1 4:m4 5:m5 6:m2 7:m5 8:m8.
  - out_last = (out_idx==8).
  - Beat completes when out_valid & out_ready; out_idx increments.
  - While stalled (out_ready=0), out_data, out_idx and out_last hold stable; out_valid never drops mid-frame.
- Final beat (idx 8 handshake):
  - frame_cnt+1.
  - If no capture event in the same cycle: next cycle out_valid=0, busy=0, IDLE.
  - If a capture event coincides: it is accepted (new words and trace loaded), stay STREAM with out_idx=0, out_valid=1. Back-to-back, no bubble, overrun not set.
- Capture event during STREAM other than the final-beat cycle: ignored. Captured data unchanged, overrun<=1 (sticky).
- state==INIT_STATE (below rst, above everything else):
  - out_valid=0, out_idx=0, busy=0, IDLE, etme_d=0, overrun=0.
  - Capture registers, trace and frame_cnt hold.
  - A frame mid-stream is abandoned and frame_cnt is not incremented.
- A capture event on the same cycle as INIT_STATE is discarded.
- Throughput: 9 cycles per frame with out_ready tied high.

Test Plan:
- Basic frame: rst, then m0=64,m1=32,m2=-16,m4=128,m5=8,m8=-64 with ctrl_etme 0->1 and out_ready=1 -> valid from next cycle for 9 cycles. Data 64,32,-16,32,128,8,-16,8,-64; last on idx 8; trace=128; frame_cnt=1; busy falls after beat 9.
- Backpressure: same frame, out_ready low on idx 2 for 3 cycles -> out_data=-16 and idx=2 held, valid stays 1; sequence completes intact in 12 cycles.
- Held level / overrun: ctrl_etme stays 1 for 20 cycles -> exactly one frame. Then toggle ctrl_etme 0->1 at idx 4 with m0 changed to 1 -> overrun=1 and the remaining beats still show the old values.
- Back-to-back: new rising edge on the idx-8 handshake cycle with m0=-1,m4=2,m8=3 -> next cycle idx=0, data=-1, trace=4, overrun=0, frame_cnt=1.
- Extremes: m0=m4=m8=20'hFFFFF (max positive, 1048575) -> trace=3145725. All three = -1048576 -> trace=-3145728 in 23 bits.
- Abort: state=INIT_STATE at idx 5 -> valid=0 and busy=0 next cycle, frame_cnt unchanged, overrun cleared. A later rising edge starts a fresh frame at idx 0.

Source files
------------

// File: rtl/sym_mat_unpack_tx_if.sv
`default_nettype none
// ============================================================================
// sym_mat_unpack_tx_if : element stream bus from the matrix unpacker | rev 1.0
// ============================================================================
interface sym_mat_unpack_tx_if #(
  parameter int DW = 21
);
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [3:0]           out_idx;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sym_mat_unpack_tx.sv
`default_nettype none
// ============================================================================
// sym_mat_unpack_tx : captures symmetric 3x3 upper triangle, streams 9 elements
// rev 1.0
// ============================================================================
module sym_mat_unpack_tx #(
  parameter logic [3:0] INIT_STATE = 4'b0010,
  parameter int         DW         = 21
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [3:0]           state,
  input  wire logic                 ctrl_etme,
  input  wire logic signed [DW-1:0] m0,
  input  wire logic signed [DW-1:0] m1,
  input  wire logic signed [DW-1:0] m2,
  input  wire logic signed [DW-1:0] m4,
  input  wire logic signed [DW-1:0] m5,
  input  wire logic signed [DW-1:0] m8,
  sym_mat_unpack_tx_if.master       out_if,
  output logic signed [DW+1:0]      trace,
  output logic                      busy,
  output logic                      overrun,
  output logic [7:0]                frame_cnt
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_STREAM = 1'b1;

  logic                 st, st_nxt;
  logic                 etme_d;
  logic [3:0]           idx;
  logic signed [DW-1:0] c0, c1, c2, c4, c5, c8;

  logic                 init_req, cap_ev, fire, final_beat, load;
  logic signed [DW+1:0] trace_sum;

  assign init_req   = (state == INIT_STATE);
  assign cap_ev     = ctrl_etme & ~etme_d;
  assign fire       = (st == ST_STREAM) & out_if.out_ready;
  assign final_beat = fire & (idx == 4'd8);
  // A new frame is only taken when idle or exactly on the closing handshake.
  assign load       = cap_ev & ((st == ST_IDLE) | final_beat);
  assign trace_sum  = {{2{m0[DW-1]}}, m0} + {{2{m4[DW-1]}}, m4} + {{2{m8[DW-1]}}, m8};

  always_ff @(posedge clk) begin
    if (rst || init_req) st <= ST_IDLE;
    else                 st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:   if (cap_ev) st_nxt = ST_STREAM;
      ST_STREAM: if (final_beat && !cap_ev) st_nxt = ST_IDLE;
      default:   st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      etme_d    <= 1'b0;
      idx       <= 4'd0;
      overrun   <= 1'b0;
      frame_cnt <= 8'd0;
      trace     <= '0;
      c0 <= '0; c1 <= '0; c2 <= '0; c4 <= '0; c5 <= '0; c8 <= '0;
    end else if (init_req) begin
      // Abort: captured words, trace and frame count are deliberately kept.
      etme_d  <= 1'b0;
      idx     <= 4'd0;
      overrun <= 1'b0;
    end else begin
      etme_d <= ctrl_etme;
      if (load) begin
        c0 <= m0; c1 <= m1; c2 <= m2; c4 <= m4; c5 <= m5; c8 <= m8;
        trace <= trace_sum;
        idx   <= 4'd0;
      end else if (fire) begin
        idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
      end
      if (final_beat) frame_cnt <= frame_cnt + 8'd1;
      if (cap_ev && (st == ST_STREAM) && !final_beat) overrun <= 1'b1;
    end
  end

  always_comb begin
    out_if.out_valid = (st == ST_STREAM);
    out_if.out_idx   = idx;
    out_if.out_last  = (idx == 4'd8);
    busy             = (st == ST_STREAM);
    case (idx)
      4'd0:       out_if.out_data = c0;
      4'd1, 4'd3: out_if.out_data = c1;
      4'd2, 4'd6: out_if.out_data = c2;
      4'd4:       out_if.out_data = c4;
      4'd5, 4'd7: out_if.out_data = c5;
      4'd8:       out_if.out_data = c8;
      default:    out_if.out_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sym_mat_unpack_tx.sv
`default_nettype none
// ============================================================================
// tb_sym_mat_unpack_tx : scoreboard bench for the matrix element streamer
// rev 1.0
// ============================================================================
module tb_sym_mat_unpack_tx;
  localparam int         DW   = 21;
  localparam logic [3:0] INIT = 4'b0010;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           state;
  logic                 ctrl_etme;
  logic signed [DW-1:0] m0, m1, m2, m4, m5, m8;
  logic signed [DW+1:0] trace;
  logic                 busy, overrun;
  logic [7:0]           frame_cnt;

  sym_mat_unpack_tx_if #(.DW(DW)) bus ();

  sym_mat_unpack_tx #(.INIT_STATE(INIT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .state(state), .ctrl_etme(ctrl_etme),
    .m0(m0), .m1(m1), .m2(m2), .m4(m4), .m5(m5), .m8(m8),
    .out_if(bus.master), .trace(trace), .busy(busy),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     idx;
    bit     last;
  } beat_t;

  beat_t q[$];
  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input longint a, b, c, d, e, f);
    m0 = DW'(a); m1 = DW'(b); m2 = DW'(c); m4 = DW'(d); m5 = DW'(e); m8 = DW'(f);
  endtask

  task automatic push_frame(input longint a, b, c, d, e, f, input int n);
    longint els[9];
    els = '{a, b, c, b, d, e, c, e, f};
    for (int i = 0; i < n; i++) q.push_back('{els[i], i, (i == 8)});
  endtask

  // Drive a clean 0->1 done edge with new words; returns one cycle after capture.
  task automatic start_frame(input longint a, b, c, d, e, f, input int n);
    ctrl_etme = 1'b0;
    tick();
    set_words(a, b, c, d, e, f);
    push_frame(a, b, c, d, e, f, n);
    ctrl_etme = 1'b1;
    tick();
    chk("first_valid", bus.out_valid, 1);
    chk("first_idx", bus.out_idx, 0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (bus.out_idx != 4'(target) && n < 40) begin
      tick();
      n++;
    end
    chk("idx_timeout", bus.out_idx, target);
  endtask

  // Monitor: every accepted beat is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_data", longint'($signed(bus.out_data)), e.data);
        chk("beat_idx", bus.out_idx, e.idx);
        chk("beat_last", bus.out_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; state = 4'd0; ctrl_etme = 1'b0; bus.out_ready = 1'b1;
    set_words(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", longint'($signed(bus.out_data)), 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_fc", frame_cnt, 0);
    chk("rst_trace", longint'(trace), 0);
    rst = 1'b0;
    tick();

    // Basic frame
    start_frame(64, 32, -16, 128, 8, -64, 9);
    chk("basic_busy", busy, 1);
    chk("basic_trace", longint'(trace), 128);
    wait_idle(n);
    exp_fc++;
    chk("basic_cycles", n, 9);
    chk("basic_fc", frame_cnt, exp_fc);
    chk("basic_valid_low", bus.out_valid, 0);

    // Backpressure on idx 2
    start_frame(64, 32, -16, 128, 8, -64, 9);
    ctrl_etme = 1'b0;
    n = 0;
    begin
      bit stalled = 1'b0;
      while (busy && n < 60) begin
        if (bus.out_idx == 4'd2 && !stalled) begin
          bus.out_ready = 1'b0;
          for (int k = 0; k < 3; k++) begin
            tick(); n++;
            chk("stall_idx", bus.out_idx, 2);
            chk("stall_data", longint'($signed(bus.out_data)), -16);
            chk("stall_valid", bus.out_valid, 1);
          end
          bus.out_ready = 1'b1;
          stalled = 1'b1;
        end else begin
          tick(); n++;
        end
      end
    end
    exp_fc++;
    chk("bp_cycles", n, 12);
    chk("bp_fc", frame_cnt, exp_fc);

    // Held level gives one frame only
    start_frame(64, 32, -16, 128, 8, -64, 9);
    repeat (19) tick();
    exp_fc++;
    chk("held_fc", frame_cnt, exp_fc);
    chk("held_busy", busy, 0);
    chk("held_overrun", overrun, 0);

    // Overrun: edge mid-frame is ignored
    start_frame(64, 32, -16, 128, 8, -64, 9);
    ctrl_etme = 1'b0;
    wait_idx(4);
    m0 = 21'sd1;
    ctrl_etme = 1'b1;
    tick();
    chk("ovr_flag", overrun, 1);
    chk("ovr_trace", longint'(trace), 128);
    wait_idle(n);
    exp_fc++;
    chk("ovr_fc", frame_cnt, exp_fc);
    chk("ovr_sticky", overrun, 1);

    // Back-to-back after a fresh reset
    rst = 1'b1; ctrl_etme = 1'b0; tick(); rst = 1'b0; exp_fc = 0;
    start_frame(64, 32, -16, 128, 8, -64, 9);
    ctrl_etme = 1'b0;
    wait_idx(8);
    set_words(-1, 0, 0, 2, 0, 3);
    push_frame(-1, 0, 0, 2, 0, 3, 9);
    ctrl_etme = 1'b1;
    tick();
    exp_fc++;
    chk("b2b_idx", bus.out_idx, 0);
    chk("b2b_valid", bus.out_valid, 1);
    chk("b2b_data", longint'($signed(bus.out_data)), -1);
    chk("b2b_trace", longint'(trace), 4);
    chk("b2b_overrun", overrun, 0);
    chk("b2b_fc", frame_cnt, exp_fc);
    wait_idle(n);
    exp_fc++;
    chk("b2b_fc2", frame_cnt, exp_fc);

    // Extremes of the trace sum
    start_frame(1048575, 0, 0, 1048575, 0, 1048575, 9);
    chk("trace_max", longint'(trace), 3145725);
    wait_idle(n);
    exp_fc++;
    start_frame(-1048576, 0, 0, -1048576, 0, -1048576, 9);
    chk("trace_min", longint'(trace), -3145728);
    wait_idle(n);
    exp_fc++;
    chk("ext_fc", frame_cnt, exp_fc);

    // Abort at idx 5 after forcing an overrun
    start_frame(64, 32, -16, 128, 8, -64, 5);
    ctrl_etme = 1'b0;
    wait_idx(3);
    ctrl_etme = 1'b1;
    tick();
    chk("abort_pre_ovr", overrun, 1);
    wait_idx(5);
    bus.out_ready = 1'b0;
    state = INIT;
    tick();
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fc", frame_cnt, exp_fc);
    chk("abort_overrun", overrun, 0);
    chk("abort_trace", longint'(trace), 128);
    state = 4'd0;
    bus.out_ready = 1'b1;
    start_frame(5, 6, 7, 8, 9, 10, 9);
    chk("fresh_data", longint'($signed(bus.out_data)), 5);
    chk("fresh_trace", longint'(trace), 23);
    wait_idle(n);
    exp_fc++;
    chk("fresh_fc", frame_cnt, exp_fc);
    tick();
    chk("sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
